// File: rtl/bus_xfer_pkg.sv
// Shared types and defaults for the bus transfer controller.
package bus_xfer_pkg;

  localparam int unsigned NUM_REGS_DEF = 8;
  localparam int unsigned QDEPTH_DEF   = 4;
  // Queued select fields are stored at this fixed width and zero-extended from SEL_W.
  localparam int unsigned SEL_W_MAX    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StLatch,
    StTurn
  } xfer_state_e;

  typedef struct packed {
    logic                 imm;
    logic [SEL_W_MAX-1:0] src;
    logic [SEL_W_MAX-1:0] dst;
    logic [7:0]           data;
  } xfer_cmd_t;

  // A command is legal when its destination exists and, for register moves, the source
  // exists and differs from the destination.
  function automatic logic cmd_is_legal(xfer_cmd_t cmd, int unsigned num_regs);
    logic bad_dst;
    logic bad_src;
    bad_dst = 32'(cmd.dst) >= num_regs;
    bad_src = !cmd.imm && ((32'(cmd.src) >= num_regs) || (cmd.src == cmd.dst));
    return !(bad_dst || bad_src);
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Command and strobe bundle of the bus transfer controller.
// BUS_SNOOP_EN adds the snoop_data/snoop_valid signals.
interface bus_xfer_ctrl_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 3
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [SEL_W-1:0]    cmd_src;
  logic [SEL_W-1:0]    cmd_dst;
  logic                cmd_imm;
  logic [7:0]          imm_data;
  logic [NUM_REGS-1:0] bus_en;
  logic [NUM_REGS-1:0] bus_load;
  logic                busy;
  logic                done;
  logic                err;
`ifdef BUS_SNOOP_EN
  logic [7:0]          snoop_data;
  logic                snoop_valid;
`endif

  // Controller side.
  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_imm, imm_data,
`ifdef BUS_SNOOP_EN
    output snoop_data, snoop_valid,
`endif
    output cmd_ready, bus_en, bus_load, busy, done, err
  );

  // Command issuer / register file side.
  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_imm, imm_data,
`ifdef BUS_SNOOP_EN
    input  snoop_data, snoop_valid,
`endif
    input  cmd_ready, bus_en, bus_load, busy, done, err
  );

endinterface

// File: rtl/xfer_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; no bypass from push to read data.
module xfer_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign rdata   = mem_q[rptr_q[AddrW-1:0]];

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AddrW + 1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (AddrW + 1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Master sequencer for the shared 8-bit tri-state bus: pops queued transfer commands and
// drives one register enable (or the immediate value) plus one load strobe per transfer,
// with a turnaround cycle between transfers.
// Optional feature macro: BUS_SNOOP_EN (captures the bus value at the end of each LATCH).
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned QDEPTH   = QDEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  bus_xfer_ctrl_if.master ctl,
  inout  wire [7:0]       bus
);

  localparam logic [NUM_REGS-1:0] OneHot = NUM_REGS'(1);

  xfer_cmd_t           push_cmd, head_cmd, work_q, work_d;
  logic                fifo_full, fifo_empty, push, pop;
  xfer_state_e         state_q, state_d;
  logic                bad_q, bad_d;
  logic [NUM_REGS-1:0] en_q, en_d, load_q, load_d;
  logic                drive_q, drive_d, done_q, done_d, err_q, err_d;

  // Pack the offered command into the queue format.
  always_comb begin
    push_cmd      = '0;
    push_cmd.imm  = ctl.cmd_imm;
    push_cmd.src  = SEL_W_MAX'(ctl.cmd_src);
    push_cmd.dst  = SEL_W_MAX'(ctl.cmd_dst);
    push_cmd.data = ctl.imm_data;
  end

  assign push = ctl.cmd_valid && !fifo_full;

  xfer_cmd_fifo #(
    .Depth (QDEPTH),
    .Width ($bits(xfer_cmd_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and registered strobes; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      bad_q   <= 1'b0;
      en_q    <= '0;
      load_q  <= '0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      bad_q   <= bad_d;
      en_q    <= en_d;
      load_q  <= load_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state: pop and validate in IDLE, then walk DRIVE -> LATCH -> TURN.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    bad_d   = bad_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          work_d  = head_cmd;
          bad_d   = !cmd_is_legal(head_cmd, NUM_REGS);
          state_d = bad_d ? StTurn : StDrive;
        end
      end
      StDrive: state_d = StLatch;
      StLatch: state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes decoded from the next state so they come straight out of flops.
  always_comb begin
    en_d    = '0;
    load_d  = '0;
    drive_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_d)
      StDrive, StLatch: begin
        if (work_d.imm) drive_d = 1'b1;
        else            en_d    = OneHot << work_d.src;
        if (state_d == StLatch) load_d = OneHot << work_d.dst;
      end
      StTurn: begin
        done_d = 1'b1;
        err_d  = bad_d;
      end
      default: ;
    endcase
  end

  assign bus           = drive_q ? work_q.data : 8'bz;
  assign ctl.cmd_ready = !fifo_full;
  assign ctl.bus_en    = en_q;
  assign ctl.bus_load  = load_q;
  assign ctl.busy      = !fifo_empty || (state_q != StIdle);
  assign ctl.done      = done_q;
  assign ctl.err       = err_q;

`ifdef BUS_SNOOP_EN
  logic [7:0] snoop_q;
  logic       snoop_valid_q;

  // Capture what the destination latched; flag only transfers that really happened.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snoop_q       <= '0;
      snoop_valid_q <= 1'b0;
    end else begin
      if (state_q == StLatch) snoop_q <= bus;
      snoop_valid_q <= done_d && !bad_d;
    end
  end

  assign ctl.snoop_data  = snoop_q;
  assign ctl.snoop_valid = snoop_valid_q;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with a behavioural 8-register bus model.
module tb_bus_xfer_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_regs = 1'b1;
  wire [7:0] bus;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.NUM_REGS(8), .SEL_W(3)) ifc ();

  bus_xfer_ctrl #(
    .NUM_REGS (8),
    .SEL_W    (3),
    .QDEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ifc.master),
    .bus   (bus)
  );

  // Register file model: drives the bus on its enable, captures on its load.
  logic [7:0] regs [8];
  logic [2:0] en_idx;

  always_comb begin
    en_idx = 3'd0;
    for (int i = 0; i < 8; i++) if (ifc.bus_en[i]) en_idx = 3'(i);
  end

  assign bus = (ifc.bus_en != 8'h00) ? regs[en_idx] : 8'bz;

  always @(posedge clk) begin
    if (init_regs) begin
      regs <= '{8'h11, 8'h22, 8'hA5, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    end else begin
      for (int i = 0; i < 8; i++) if (ifc.bus_load[i]) regs[i] <= bus;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic imm, input logic [2:0] src, input logic [2:0] dst,
                     input logic [7:0] data);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_imm   = imm;
    ifc.cmd_src   = src;
    ifc.cmd_dst   = dst;
    ifc.imm_data  = data;
    tick();
    ifc.cmd_valid = 1'b0;
  endtask

  logic [2:0] q_src [5];
  logic [2:0] q_dst [5];
  int         done_at [5];
  int         n_done;
  int         k;
  int         multi;
  logic       acc;

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_imm   = 1'b0;
    ifc.cmd_src   = '0;
    ifc.cmd_dst   = '0;
    ifc.imm_data  = '0;
    repeat (2) tick();

    // Reset state.
    check("rst_en", 32'(ifc.bus_en), 32'h00);
    check("rst_load", 32'(ifc.bus_load), 32'h00);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_err", 32'(ifc.err), 32'd0);
    check("rst_ready", 32'(ifc.cmd_ready), 32'd1);
    check("rst_bus_z", 32'(bus === 8'bz), 32'd1);
    reset = 1'b0;
    init_regs = 1'b0;
    tick();

    // Register move 2 -> 5.
    put(1'b0, 3'd2, 3'd5, 8'h00);
    check("t1_queued_busy", 32'(ifc.busy), 32'd1);
    check("t1_queued_en", 32'(ifc.bus_en), 32'h00);
    tick();
    check("t1_drive_en", 32'(ifc.bus_en), 32'h04);
    check("t1_drive_load", 32'(ifc.bus_load), 32'h00);
    tick();
    check("t1_latch_en", 32'(ifc.bus_en), 32'h04);
    check("t1_latch_load", 32'(ifc.bus_load), 32'h20);
    check("t1_latch_bus", 32'(bus), 32'hA5);
    tick();
    check("t1_turn_en", 32'(ifc.bus_en), 32'h00);
    check("t1_turn_load", 32'(ifc.bus_load), 32'h00);
    check("t1_turn_done", 32'(ifc.done), 32'd1);
    check("t1_turn_err", 32'(ifc.err), 32'd0);
    check("t1_reg5", 32'(regs[5]), 32'hA5);
    tick();
    check("t1_idle_done", 32'(ifc.done), 32'd0);
    check("t1_idle_busy", 32'(ifc.busy), 32'd0);

    // Immediate 0x3C -> r7.
    put(1'b1, 3'd0, 3'd7, 8'h3C);
    tick();
    check("t2_drive_bus", 32'(bus), 32'h3C);
    check("t2_drive_en", 32'(ifc.bus_en), 32'h00);
    check("t2_drive_load", 32'(ifc.bus_load), 32'h00);
    tick();
    check("t2_latch_bus", 32'(bus), 32'h3C);
    check("t2_latch_load", 32'(ifc.bus_load), 32'h80);
    check("t2_latch_en", 32'(ifc.bus_en), 32'h00);
    tick();
    check("t2_turn_bus_z", 32'(bus === 8'bz), 32'd1);
    check("t2_turn_done", 32'(ifc.done), 32'd1);
    check("t2_reg7", 32'(regs[7]), 32'h3C);
    tick();

    // Illegal 4 -> 4 followed by legal 0 -> 1, offered back to back.
    ifc.cmd_valid = 1'b1;
    ifc.cmd_imm   = 1'b0;
    ifc.cmd_src   = 3'd4;
    ifc.cmd_dst   = 3'd4;
    tick();
    ifc.cmd_src   = 3'd0;
    ifc.cmd_dst   = 3'd1;
    tick();
    ifc.cmd_valid = 1'b0;
    check("t3_rej_done", 32'(ifc.done), 32'd1);
    check("t3_rej_err", 32'(ifc.err), 32'd1);
    check("t3_rej_strobes", {ifc.bus_en, ifc.bus_load}, 32'h0000);
    tick();
    check("t3_idle_done", 32'(ifc.done), 32'd0);
    check("t3_idle_err", 32'(ifc.err), 32'd0);
    check("t3_idle_strobes", {ifc.bus_en, ifc.bus_load}, 32'h0000);
    tick();
    check("t3_drive_en", 32'(ifc.bus_en), 32'h01);
    tick();
    check("t3_latch_strobes", {ifc.bus_en, ifc.bus_load}, 32'h0102);
    tick();
    check("t3_turn_done", 32'(ifc.done), 32'd1);
    check("t3_turn_err", 32'(ifc.err), 32'd0);
    check("t3_reg1", 32'(regs[1]), 32'h11);
    tick();

    // Five commands offered without gaps.
    q_src = '{3'd3, 3'd6, 3'd7, 3'd4, 3'd0};
    q_dst = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
    k = 0;
    n_done = 0;
    multi = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_src = q_src[0];
    ifc.cmd_dst = q_dst[0];
    for (int c = 1; c <= 24; c++) begin
      acc = ifc.cmd_valid && ifc.cmd_ready;
      tick();
      if (acc) begin
        k++;
        if (k < 5) begin
          ifc.cmd_src = q_src[k];
          ifc.cmd_dst = q_dst[k];
        end else begin
          ifc.cmd_valid = 1'b0;
        end
      end
      if (c == 4) check("t4_ready_c4", 32'(ifc.cmd_ready), 32'd1);
      if (c == 5) check("t4_ready_full", 32'(ifc.cmd_ready), 32'd0);
      if (c == 6) check("t4_ready_back", 32'(ifc.cmd_ready), 32'd1);
      if (!$onehot0(ifc.bus_en) || !$onehot0(ifc.bus_load)) multi++;
      if (ifc.done) begin
        if (n_done < 5) done_at[n_done] = c;
        n_done++;
      end
    end
    check("t4_accepted", 32'(k), 32'd5);
    check("t4_multihot", 32'(multi), 32'd0);
    check("t4_ndone", 32'(n_done), 32'd5);
    for (int i = 0; i < 5; i++) check("t4_done_cycle", 32'(done_at[i]), 32'(4 * (i + 1)));
    check("t4_reg0", 32'(regs[0]), 32'h33);
    check("t4_reg1", 32'(regs[1]), 32'h66);
    check("t4_reg2", 32'(regs[2]), 32'h3C);
    check("t4_reg5", 32'(regs[5]), 32'h44);
    check("t4_reg6_order", 32'(regs[6]), 32'h33);
    check("t4_idle_busy", 32'(ifc.busy), 32'd0);

    // Reset asserted during LATCH of 3 -> 4, with 2 -> 7 still queued.
    put(1'b0, 3'd3, 3'd4, 8'h00);
    put(1'b0, 3'd2, 3'd7, 8'h00);
    tick();
    check("t5_latch_strobes", {ifc.bus_en, ifc.bus_load}, 32'h0810);
    reset = 1'b1;
    #1;
    check("t5_async_en", 32'(ifc.bus_en), 32'h00);
    check("t5_async_load", 32'(ifc.bus_load), 32'h00);
    check("t5_async_busy", 32'(ifc.busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t5_busy", 32'(ifc.busy), 32'd0);
    check("t5_ready", 32'(ifc.cmd_ready), 32'd1);
    check("t5_strobes", {ifc.bus_en, ifc.bus_load}, 32'h0000);
    check("t5_reg4_kept", 32'(regs[4]), 32'h44);
    check("t5_reg7_kept", 32'(regs[7]), 32'h3C);

`ifdef BUS_SNOOP_EN
    // Snoop capture for a register move of 0x5A and an immediate 0xFF.
    put(1'b1, 3'd0, 3'd3, 8'h5A);
    repeat (4) tick();
    put(1'b0, 3'd3, 3'd0, 8'h00);
    repeat (3) tick();
    check("t6_snoop_move", 32'(ifc.snoop_data), 32'h5A);
    check("t6_snoop_valid", 32'(ifc.snoop_valid), 32'd1);
    check("t6_reg0", 32'(regs[0]), 32'h5A);
    tick();
    put(1'b1, 3'd0, 3'd1, 8'hFF);
    repeat (3) tick();
    check("t6_snoop_imm", 32'(ifc.snoop_data), 32'hFF);
    check("t6_snoop_valid_imm", 32'(ifc.snoop_valid), 32'd1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
